// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums TERMS products per result with a valid/ready result handshake
// Optional feature: define PRODUCT_ACCUMULATOR_SATURATE_EN to saturate the sum and report out_sat;
// without it the sum wraps modulo 2^ACC_W and out_sat is tied low.
module product_accumulator #(
   parameter int WIDTH = 4,
   parameter int TERMS = 4,
   parameter int ACC_W = 4*WIDTH+4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4*WIDTH-1:0] in_product,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic               out_sat
);

   localparam int CNT_W = $clog2(TERMS+1);

   typedef enum logic {ST_ACC = 1'b0, ST_DONE = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept;
   logic               last_term;
   logic               take_result;
   logic [ACC_W-1:0]   acc_add;

   assign accept      = in_valid && in_ready;
   assign last_term   = (cnt_q == CNT_W'(TERMS-1));
   assign take_result = out_valid && out_ready;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
   localparam int SUM_W = ACC_W + 1;

   logic               sat_q, sat_d;
   logic [SUM_W-1:0]   sum_full;
   logic               add_ovf;

   // Carry out of the widened adder means the true sum no longer fits.
   always_comb begin
      sum_full = {1'b0, acc_q} + SUM_W'(in_product);
      add_ovf  = sum_full[ACC_W];
      acc_add  = add_ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
   end

   // Sticky saturation flag, cleared together with the accumulator.
   always_comb begin
      sat_d = sat_q;
      if (state_q == ST_ACC) begin
         if (clear)
            sat_d = 1'b0;
         else if (accept && add_ovf)
            sat_d = 1'b1;
      end else if (take_result) begin
         sat_d = 1'b0;
      end
   end

   // Saturation flag register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         sat_q <= 1'b0;
      else
         sat_q <= sat_d;
   end

   assign out_sat = sat_q;
`else
   // Plain modulo-2^ACC_W addition.
   always_comb begin
      acc_add = acc_q + ACC_W'(in_product);
   end

   assign out_sat = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_ACC;
      else
         state_q <= state_d;
   end

   // Next state: finish on the accept of the last term, return once the result is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACC:  if (!clear && accept && last_term) state_d = ST_DONE;
         ST_DONE: if (take_result)                   state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
   end

   // Outputs: accept terms while accumulating, present the result while done.
   always_comb begin
      in_ready  = (state_q == ST_ACC);
      out_valid = (state_q == ST_DONE);
   end

   // Accumulator and term counter; clear only acts while accumulating.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (state_q == ST_ACC) begin
         if (clear) begin
            acc_d = '0;
            cnt_d = '0;
         end else if (accept) begin
            acc_d = acc_add;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (take_result) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_sum = acc_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized and directed self-checking bench for product_accumulator
module tb_product_accumulator;

   localparam int WIDTH = 4;
   localparam int TERMS = 4;
   localparam int ACC_W = 20;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, clear, in_valid, out_ready;
   logic [15:0] in_product;
   logic        in_ready, out_valid, out_sat;
   logic [19:0] out_sum;

   logic        ov_in_valid;
   logic [7:0]  ov_in_product;
   logic        ov_in_ready, ov_out_valid, ov_out_sat;
   logic [7:0]  ov_out_sum;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: list of accepted products of the current result and a pending flag.
   longint m_terms[$];
   bit     m_done;

   product_accumulator #(.WIDTH(WIDTH), .TERMS(TERMS), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_sat(out_sat)
   );

   product_accumulator #(.WIDTH(2), .TERMS(4), .ACC_W(8)) dut_ov (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(ov_in_valid), .in_ready(ov_in_ready), .in_product(ov_in_product),
      .out_valid(ov_out_valid), .out_ready(out_ready),
      .out_sum(ov_out_sum), .out_sat(ov_out_sat)
   );

   function automatic longint model_sum();
      longint s = 0;
      foreach (m_terms[i]) s += m_terms[i];
      return s % (64'd1 << ACC_W);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one cycle of stimulus to the main instance and advance the model by its rules.
   task automatic drive_cycle(input bit v, input logic [15:0] p, input bit clr, input bit ordy);
      in_valid   = v;
      in_product = p;
      clear      = clr;
      out_ready  = ordy;
      if (!m_done) begin
         if (clr) begin
            m_terms.delete();
         end else if (v) begin
            m_terms.push_back(longint'(p));
            if (m_terms.size() == TERMS) m_done = 1'b1;
         end
      end else if (ordy) begin
         m_terms.delete();
         m_done = 1'b0;
      end
      tick();
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      in_valid      = 1'b1;
      in_product    = 16'hffff;
      clear         = 1'b1;
      out_ready     = 1'b1;
      ov_in_valid   = 1'b1;
      ov_in_product = 8'hff;
      tick();
      tick();
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      clear       = 1'b0;
      ov_in_valid = 1'b0;
      m_terms.delete();
      m_done = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_sum !== 20'd0)   begin n_fail++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
      n_checks++; if (out_sat !== 1'b0)    begin n_fail++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
      n_checks++; if (ov_out_sum !== 8'd0) begin n_fail++; $display("FAIL reset_ov_sum got %0d want 0", ov_out_sum); end
   endtask

   task automatic test_nominal();
      logic [15:0] prods [4] = '{16'd2, 16'd6, 16'd12, 16'd20};
      int partial [4] = '{2, 8, 20, 40};
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, prods[i], 1'b0, 1'b1);
         n_checks++; if (out_sum !== 20'(partial[i])) begin n_fail++; $display("FAIL nominal_partial[%0d] got %0d want %0d", i, out_sum, partial[i]); end
      end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nominal_valid got %b want 1", out_valid); end
      n_checks++; if (out_sat !== 1'b0)   begin n_fail++; $display("FAIL nominal_sat got %b want 0", out_sat); end
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL nominal_in_ready_done got %b want 0", in_ready); end
      drive_cycle(1'b0, 16'd0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_valid_pulse got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL nominal_in_ready_after got %b want 1", in_ready); end
      n_checks++; if (out_sum !== 20'd0)  begin n_fail++; $display("FAIL nominal_sum_after got %0d want 0", out_sum); end
   endtask

   task automatic test_backpressure();
      logic [15:0] prods [4] = '{16'd2, 16'd6, 16'd12, 16'd20};
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, prods[i], 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", c, out_valid); end
         n_checks++; if (out_sum !== 20'd40) begin n_fail++; $display("FAIL bp_sum[%0d] got %0d want 40", c, out_sum); end
         n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
         drive_cycle(1'b1, 16'd9, 1'b0, (c == 3));
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
      n_checks++; if (out_sum !== 20'd0)  begin n_fail++; $display("FAIL bp_no_same_cycle_accept got %0d want 0", out_sum); end
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_gapped();
      for (int i = 1; i <= 4; i++) begin
         drive_cycle(1'b1, 16'(i), 1'b0, 1'b0);
         if (i < 4) drive_cycle(1'b0, 16'd77, 1'b0, 1'b0);
      end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gapped_valid got %b want 1", out_valid); end
      n_checks++; if (out_sum !== 20'd10) begin n_fail++; $display("FAIL gapped_sum got %0d want 10", out_sum); end
      drive_cycle(1'b0, 16'd0, 1'b0, 1'b1);
   endtask

   task automatic test_clear();
      drive_cycle(1'b1, 16'd5, 1'b0, 1'b1);
      drive_cycle(1'b1, 16'd7, 1'b0, 1'b1);
      drive_cycle(1'b1, 16'd99, 1'b1, 1'b1);
      n_checks++; if (out_sum !== 20'd0) begin n_fail++; $display("FAIL clear_sum got %0d want 0", out_sum); end
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 16'd1, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_valid got %b want 1", out_valid); end
      n_checks++; if (out_sum !== 20'd4)  begin n_fail++; $display("FAIL clear_result got %0d want 4", out_sum); end
      drive_cycle(1'b0, 16'd0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_in_done_valid got %b want 1", out_valid); end
      n_checks++; if (out_sum !== 20'd4)  begin n_fail++; $display("FAIL clear_in_done_sum got %0d want 4", out_sum); end
      drive_cycle(1'b0, 16'd0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16'd3, 1'b0, 1'b1);
      do_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
      n_checks++; if (out_sum !== 20'd0)  begin n_fail++; $display("FAIL rstmid_sum got %0d want 0", out_sum); end
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 16'd3, 1'b0, 1'b0);
      n_checks++; if (out_sum !== 20'd12) begin n_fail++; $display("FAIL rstmid_result got %0d want 12", out_sum); end
      do_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_done_valid got %b want 0", out_valid); end
      n_checks++; if (out_sum !== 20'd0)  begin n_fail++; $display("FAIL rst_in_done_sum got %0d want 0", out_sum); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive_cycle(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 3) != 0));
         n_checks++;
         if (out_valid !== m_done || in_ready !== !m_done || out_sum !== 20'(model_sum()) || out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL random[%0d] got v=%b r=%b sum=%0d sat=%b want v=%b r=%b sum=%0d sat=0",
                     c, out_valid, in_ready, out_sum, out_sat, m_done, !m_done, model_sum());
         end
      end
   endtask

   task automatic test_overflow();
      int prods [2] = '{15, 255};
      int total, exp_sum, exp_sat;
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         total = 4 * prods[r];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
         exp_sum = (total > 255) ? 255 : total;
         exp_sat = (total > 255) ? 1 : 0;
`else
         exp_sum = total % 256;
         exp_sat = 0;
`endif
         for (int i = 0; i < 4; i++) begin
            ov_in_valid   = 1'b1;
            ov_in_product = 8'(prods[r]);
            tick();
         end
         ov_in_valid = 1'b0;
         n_checks++; if (ov_out_valid !== 1'b1)          begin n_fail++; $display("FAIL ovf_valid[%0d] got %b want 1", r, ov_out_valid); end
         n_checks++; if (ov_out_sum !== 8'(exp_sum))     begin n_fail++; $display("FAIL ovf_sum[%0d] got %0d want %0d", r, ov_out_sum, exp_sum); end
         n_checks++; if (ov_out_sat !== 1'(exp_sat))     begin n_fail++; $display("FAIL ovf_sat[%0d] got %b want %0d", r, ov_out_sat, exp_sat); end
         tick();
         n_checks++; if (ov_out_sat !== 1'b0 || ov_out_sum !== 8'd0) begin n_fail++; $display("FAIL ovf_consumed[%0d] got sum=%0d sat=%b want 0 0", r, ov_out_sum, ov_out_sat); end
      end
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_product = '0;
      ov_in_valid = 1'b0; ov_in_product = '0;
      m_done = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_gapped();
      test_clear();
      test_reset_mid();
      do_reset();
      test_random();
      do_reset();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
